control_pipe: RTL and testbench

Carries the decoded control bundle from the ID stage through the EX, MEM and WB pipeline registers. It also generates the hazard-side controls that consume that bundle: a load-use stall, bubble insertion, flush on a taken branch or jump, destination-register selection, and the EX-stage forwarding selects. It sits between the opcode control decoder in ID and the datapath stage registers and muxes, and owns every control bit held in the pipeline.

---
 rtl/control_pkg.sv | 44 ++++
 rtl/control_pipe_stage_reg.sv | 24 ++
 rtl/control_pipe.sv | 103 ++++++++++
 tb/tb_control_pipe.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared widths, control-bundle bit positions and forwarding encodings for the
// pipeline control path.
package control_pkg;

    localparam int CTRL_W         = 13;
    localparam int CTRL_JUMP      = 12;
    localparam int CTRL_REGDST    = 11;
    localparam int CTRL_ALUSRC    = 10;
    localparam int CTRL_MEMTOREG  = 9;
    localparam int CTRL_REGWRITE  = 8;
    localparam int CTRL_MEMREAD   = 7;
    localparam int CTRL_MEMWRITE  = 6;
    localparam int CTRL_BRANCHNE  = 5;
    localparam int CTRL_BRANCHEQ  = 4;
    localparam int CTRL_ALUOP_MSB = 3;
    localparam int CTRL_ALUOP_LSB = 0;

    localparam logic [4:0] REG_RA  = 5'd31;
    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Operand source for one EX register; the MEM producer is newer than WB.
    function automatic logic [1:0] fwd_select(
        input logic       mem_rw,
        input logic [4:0] mem_reg,
        input logic       wb_rw,
        input logic [4:0] wb_reg,
        input logic [4:0] src
    );
        logic [1:0] sel;
        if (mem_rw && (mem_reg != REG_ZERO) && (mem_reg == src)) begin
            sel = FWD_MEM;
        end else if (wb_rw && (wb_reg != REG_ZERO) && (wb_reg == src)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/control_pipe_stage_reg.sv
// Pipeline stage register: asynchronous active-low reset plus a synchronous
// clear that loads a bubble.
module ctrl_stage_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Stage storage: reset or clear load all-zero, otherwise advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= {W{1'b0}};
        end else if (clear) begin
            q <= {W{1'b0}};
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/control_pipe.sv
// Control bundle pipeline ID->EX->MEM->WB with load-use stall, flush bubbles,
// destination-register selection and EX operand forwarding selects.
module control_pipe
    import control_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_jr,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic              flush,
    output logic              stall,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_jr,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_wreg,
    output logic [CTRL_W-1:0] mem_ctrl,
    output logic [4:0]        mem_wreg,
    output logic              wb_regwrite,
    output logic              wb_memtoreg,
    output logic [4:0]        wb_wreg,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b
);

    localparam int EX_W  = CTRL_W + 1 + 15;
    localparam int MEM_W = CTRL_W + 5;
    localparam int WB_W  = 7;

    logic [4:0]       id_wreg_s;
    logic             hz_s;
    logic             ex_clear_s;
    logic [EX_W-1:0]  ex_d_s;
    logic [EX_W-1:0]  ex_q_s;
    logic [MEM_W-1:0] mem_d_s;
    logic [MEM_W-1:0] mem_q_s;
    logic [WB_W-1:0]  wb_d_s;
    logic [WB_W-1:0]  wb_q_s;

    // Destination register: JAL links into r31, else rd or rt by RegDst.
    always_comb begin
        id_wreg_s = id_rt;
        if (id_ctrl[CTRL_JUMP] && id_ctrl[CTRL_REGWRITE]) begin
            id_wreg_s = REG_RA;
        end else if (id_ctrl[CTRL_REGDST]) begin
            id_wreg_s = id_rd;
        end else begin
            id_wreg_s = id_rt;
        end
    end

    // Load-use detection; a flushed ID instruction must not freeze the front end.
    always_comb begin
        hz_s = ex_ctrl[CTRL_MEMREAD] && (ex_rt != REG_ZERO) &&
               ((ex_rt == id_rs) || (ex_rt == id_rt));
        stall      = hz_s && !flush;
        ex_clear_s = hz_s || flush;
    end

    // EX operand forwarding selects.
    always_comb begin
        forward_a = fwd_select(mem_ctrl[CTRL_REGWRITE], mem_wreg,
                               wb_regwrite, wb_wreg, ex_rs);
        forward_b = fwd_select(mem_ctrl[CTRL_REGWRITE], mem_wreg,
                               wb_regwrite, wb_wreg, ex_rt);
    end

    assign ex_d_s  = {id_ctrl, id_jr, id_rs, id_rt, id_wreg_s};
    assign mem_d_s = {ex_ctrl, ex_wreg};
    assign wb_d_s  = {mem_ctrl[CTRL_REGWRITE], mem_ctrl[CTRL_MEMTOREG], mem_wreg};

    ctrl_stage_reg #(.W(EX_W)) u_ex_reg (
        .clk   (clk),
        .rst_n (reset),
        .clear (ex_clear_s),
        .d     (ex_d_s),
        .q     (ex_q_s)
    );

    ctrl_stage_reg #(.W(MEM_W)) u_mem_reg (
        .clk   (clk),
        .rst_n (reset),
        .clear (1'b0),
        .d     (mem_d_s),
        .q     (mem_q_s)
    );

    ctrl_stage_reg #(.W(WB_W)) u_wb_reg (
        .clk   (clk),
        .rst_n (reset),
        .clear (1'b0),
        .d     (wb_d_s),
        .q     (wb_q_s)
    );

    assign {ex_ctrl, ex_jr, ex_rs, ex_rt, ex_wreg} = ex_q_s;
    assign {mem_ctrl, mem_wreg}                    = mem_q_s;
    assign {wb_regwrite, wb_memtoreg, wb_wreg}     = wb_q_s;

endmodule

// File: tb/tb_control_pipe.sv
// Randomised and directed checks of control_pipe against a stage-list
// reference model of the pipeline control rules.
module tb_control_pipe;

    logic        clk;
    logic        reset;
    logic [12:0] id_ctrl;
    logic        id_jr;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        flush;
    logic        stall;
    logic [12:0] ex_ctrl, mem_ctrl;
    logic        ex_jr;
    logic [4:0]  ex_rs, ex_rt, ex_wreg, mem_wreg, wb_wreg;
    logic        wb_regwrite, wb_memtoreg;
    logic [1:0]  forward_a, forward_b;

    control_pipe dut (
        .clk(clk), .reset(reset), .id_ctrl(id_ctrl), .id_jr(id_jr),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
        .stall(stall), .ex_ctrl(ex_ctrl), .ex_jr(ex_jr), .ex_rs(ex_rs),
        .ex_rt(ex_rt), .ex_wreg(ex_wreg), .mem_ctrl(mem_ctrl),
        .mem_wreg(mem_wreg), .wb_regwrite(wb_regwrite),
        .wb_memtoreg(wb_memtoreg), .wb_wreg(wb_wreg),
        .forward_a(forward_a), .forward_b(forward_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [12:0] ctrl;
        logic        jr;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wreg;
    } slot_t;

    // Model: the instruction in each stage; WB keeps only what it exposes.
    slot_t      m_ex, m_mem;
    logic       m_wb_rw, m_wb_mtr;
    logic [4:0] m_wb_reg;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [4:0] dest_of(input logic [12:0] c, input logic [4:0] rt, input logic [4:0] rd);
        if (c[12] && c[8]) return 5'd31;
        if (c[11]) return rd;
        return rt;
    endfunction

    // The newest in-flight writer of a nonzero register supplies the operand.
    function automatic logic [1:0] exp_fwd(input logic [4:0] src);
        if (src == 5'd0) return 2'b00;
        if (m_mem.ctrl[8] && m_mem.wreg == src) return 2'b10;
        if (m_wb_rw && m_wb_reg == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic model_hz();
        return m_ex.ctrl[7] && (m_ex.rt != 5'd0) && (m_ex.rt == id_rs || m_ex.rt == id_rt);
    endfunction

    task automatic model_reset();
        m_ex = '0;
        m_mem = '0;
        m_wb_rw = 1'b0;
        m_wb_mtr = 1'b0;
        m_wb_reg = 5'd0;
    endtask

    task automatic check_comb();
        check_val("stall", {31'd0, stall}, {31'd0, model_hz() && !flush});
        check_val("fwd_a", {30'd0, forward_a}, {30'd0, exp_fwd(m_ex.rs)});
        check_val("fwd_b", {30'd0, forward_b}, {30'd0, exp_fwd(m_ex.rt)});
    endtask

    task automatic check_regs();
        check_val("ex_bundle", {3'd0, ex_ctrl, ex_jr, ex_rs, ex_rt, ex_wreg}, {3'd0, m_ex});
        check_val("mem_ctrl", {19'd0, mem_ctrl}, {19'd0, m_mem.ctrl});
        check_val("mem_wreg", {27'd0, mem_wreg}, {27'd0, m_mem.wreg});
        check_val("wb", {25'd0, wb_regwrite, wb_memtoreg, wb_wreg}, {25'd0, m_wb_rw, m_wb_mtr, m_wb_reg});
    endtask

    task automatic set_id(input logic [12:0] c, input logic jr, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd, input logic fl);
        id_ctrl = c;
        id_jr   = jr;
        id_rs   = rs;
        id_rt   = rt;
        id_rd   = rd;
        flush   = fl;
        #1;
        check_comb();
    endtask

    task automatic tick();
        slot_t nxt;
        if (flush || model_hz()) begin
            nxt = '0;
        end else begin
            nxt = '{ctrl: id_ctrl, jr: id_jr, rs: id_rs, rt: id_rt,
                    wreg: dest_of(id_ctrl, id_rt, id_rd)};
        end
        @(posedge clk);
        m_wb_rw  = m_mem.ctrl[8];
        m_wb_mtr = m_mem.ctrl[9];
        m_wb_reg = m_mem.wreg;
        m_mem    = m_ex;
        m_ex     = nxt;
        #1;
        check_regs();
    endtask

    task automatic drive(input logic [12:0] c, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic fl);
        set_id(c, 1'b0, rs, rt, rd, fl);
        tick();
    endtask

    initial begin
        reset = 1'b0;
        id_ctrl = 13'd0; id_jr = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0; flush = 1'b0;
        model_reset();
        #2;
        check_regs();
        check_comb();
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Pass-through of ADDI to rt=5.
        drive(13'h0504, 5'd1, 5'd5, 5'd0, 1'b0);
        check_val("pt_ex_ctrl", {19'd0, ex_ctrl}, 32'h0504);
        check_val("pt_ex_wreg", {27'd0, ex_wreg}, 32'd5);
        drive(13'h0000, 5'd0, 5'd0, 5'd0, 1'b0);
        check_val("pt_mem_wreg", {27'd0, mem_wreg}, 32'd5);
        drive(13'h0000, 5'd0, 5'd0, 5'd0, 1'b0);
        check_val("pt_wb_rw", {31'd0, wb_regwrite}, 32'd1);
        check_val("pt_wb_wreg", {27'd0, wb_wreg}, 32'd5);

        // Reset pulled between edges discards the in-flight ADDI.
        drive(13'h0504, 5'd1, 5'd6, 5'd0, 1'b0);
        reset = 1'b0;
        #2;
        model_reset();
        check_val("rst_ex_ctrl", {19'd0, ex_ctrl}, 32'd0);
        check_val("rst_ex_wreg", {27'd0, ex_wreg}, 32'd0);
        check_regs();
        check_comb();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(13'h0000, 5'd0, 5'd0, 5'd0, 1'b0);
            check_val("rst_no_stale_rw", {31'd0, wb_regwrite | mem_ctrl[8]}, 32'd0);
        end

        // Load-use: LW r8 then a consumer of r8.
        drive(13'h0782, 5'd2, 5'd8, 5'd0, 1'b0);
        set_id(13'h0902, 1'b0, 5'd8, 5'd9, 5'd10, 1'b0);
        check_val("lu_stall", {31'd0, stall}, 32'd1);
        tick();
        check_val("lu_bubble", {19'd0, ex_ctrl}, 32'd0);
        set_id(13'h0902, 1'b0, 5'd8, 5'd9, 5'd10, 1'b0);
        check_val("lu_stall_clear", {31'd0, stall}, 32'd0);
        tick();
        // One bubble later the load has moved on to WB.
        check_val("lu_fwd_a", {30'd0, forward_a}, 32'd1);

        // Load to r0 never stalls.
        drive(13'h0782, 5'd2, 5'd0, 5'd0, 1'b0);
        set_id(13'h0902, 1'b0, 5'd0, 5'd0, 5'd11, 1'b0);
        check_val("lu_r0_stall", {31'd0, stall}, 32'd0);
        tick();

        // Forward priority: MEM over WB, then WB once MEM stops writing.
        drive(13'h0504, 5'd0, 5'd3, 5'd0, 1'b0);
        drive(13'h0504, 5'd0, 5'd3, 5'd0, 1'b0);
        drive(13'h0902, 5'd3, 5'd0, 5'd12, 1'b0);
        check_val("prio_mem", {30'd0, forward_a}, 32'd2);
        drive(13'h0504, 5'd0, 5'd3, 5'd0, 1'b0);
        drive(13'h0000, 5'd0, 5'd3, 5'd0, 1'b0);
        drive(13'h0902, 5'd3, 5'd0, 5'd12, 1'b0);
        check_val("prio_wb", {30'd0, forward_a}, 32'd1);

        // Flush coinciding with a load-use hazard.
        drive(13'h0782, 5'd1, 5'd4, 5'd0, 1'b0);
        set_id(13'h0902, 1'b0, 5'd4, 5'd0, 5'd13, 1'b1);
        check_val("fl_stall", {31'd0, stall}, 32'd0);
        tick();
        check_val("fl_bubble", {19'd0, ex_ctrl}, 32'd0);

        // JAL links to r31 and forwards to a consumer.
        drive(13'h1100, 5'd0, 5'd0, 5'd7, 1'b0);
        check_val("jal_wreg", {27'd0, ex_wreg}, 32'd31);
        drive(13'h0902, 5'd31, 5'd0, 5'd14, 1'b0);
        check_val("jal_fwd", {30'd0, forward_a}, 32'd2);

        // Randomised traffic over a small register set to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            logic [12:0] c;
            c = 13'($urandom);
            if ($urandom_range(0, 3) == 0) c[7] = 1'b1;
            set_id(c, 1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
